mac_result_reader: RTL and testbench
====================================

MAC_RESULT_READER -- requirements
Module: mac_result_reader

Interface
REQ-001 The block SHALL use one clock, Clk, and one synchronous, active-high reset, reset, both sampled on the rising edge of Clk.
REQ-002 Parameter CAP_DELAY, default 2, SHALL set the cycles from the COMP cycle to the capture of macOut; legal range 1..4.
REQ-003 Clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to read out numRows rows; sampled only in IDLE.
REQ-006 numRows  input  5  number of rows to read; latched when start is accepted.
REQ-007 COMP  output  1  compute/select strobe to the MAC array.
REQ-008 rowResult  output  4  row index presented to the MAC array.
REQ-009 macOut  input  272  16 lanes of 17 bits, lane n on bits [17n+16:17n].
REQ-010 outData  output  17  current result word.
REQ-011 outLane  output  4  lane index of outData.
REQ-012 outRow  output  4  row index of outData.
REQ-013 outValid  output  1  outData, outLane and outRow are valid.
REQ-014 outReady  input  1  downstream accepts the word; a transfer occurs on a cycle where outValid and outReady are both 1.
REQ-015 busy  output  1  readout in progress.
REQ-016 done  output  1  one-cycle pulse when readout completes.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT, DRAIN.
REQ-018 In IDLE, start=1 with numRows in 1..16 SHALL latch numRows, set row=0 and enter ISSUE on the next cycle.
REQ-019 start with numRows=0 SHALL be ignored; numRows>16 SHALL be clamped to 16.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 ISSUE SHALL last exactly 1 cycle with COMP=1 and rowResult=row, then enter WAIT.
REQ-022 COMP SHALL be 0 in every state except ISSUE.
REQ-023 rowResult SHALL hold the current row from ISSUE through the end of DRAIN.
REQ-024 WAIT SHALL last CAP_DELAY cycles; on the edge ending the last WAIT cycle, all 16 lanes of macOut SHALL be captured into an internal buffer, lane=0, and the FSM SHALL enter DRAIN.
REQ-025 In DRAIN, the block SHALL drive outValid=1, outData=buffer[lane], outLane=lane and outRow=row, all registered.
REQ-026 In DRAIN, outData, outLane and outRow SHALL remain stable while outReady=0.
REQ-027 On each DRAIN transfer, lane SHALL increment; the transfer of lane 15 SHALL end the row.
REQ-028 At end of row, if row<numRows-1 the FSM SHALL increment row and enter ISSUE next cycle; otherwise it SHALL enter IDLE with done=1 for exactly that one cycle.
REQ-029 outValid SHALL be 0 outside DRAIN, including during a back-to-back transition from lane 15 to the next ISSUE.
REQ-030 busy SHALL be 1 in ISSUE, WAIT and DRAIN, and 0 in IDLE, including the done cycle.
REQ-031 A start asserted in the done cycle SHALL be accepted.
REQ-032 Data SHALL pass unmodified at full 17-bit width, with no sign handling.
REQ-033 With outReady held at 1, each row SHALL take 1+CAP_DELAY+16 cycles; with CAP_DELAY=2, N rows complete with done in cycle 19N+1 after the start edge.

Reset
REQ-034 reset=1 SHALL, on the next edge, force IDLE and set COMP, rowResult, outData, outLane, outRow, outValid, busy and done to 0 and clear the buffer, row and lane counters.
REQ-035 Reset SHALL take priority over start and any handshake in the same cycle.
REQ-036 A reset asserted mid-readout SHALL abort the readout with no done pulse, and start SHALL be accepted in the first cycle after reset deasserts.

Verification
REQ-037 Reset, then hold macOut=all ones with start=0 for 50 cycles -> all outputs 0 and COMP never asserted.
REQ-038 numRows=1, CAP_DELAY=2, outReady=1, bench MAC model drives lane n = 17'h100*r+n two cycles after COMP -> COMP high 1 cycle with rowResult=0; outData 0..15 with outLane 0..15 in cycles 4..19; done in cycle 20.
REQ-039 numRows=16, outReady random at 50% -> 256 transfers in row-major order, 16 COMP pulses with rowResult 0..15, outData stable during stalls, exactly one done.
REQ-040 start during busy, start with numRows=0, and start with numRows=20 -> first two ignored (no busy, no done); third reads exactly 16 rows.
REQ-041 Reset asserted in DRAIN at row 3 lane 7 -> next cycle all outputs 0 with no done; a new start with numRows=2 then completes 32 transfers.
REQ-042 macOut lane 5 = 17'h1FFFF, other lanes 17'h00001 -> outData=17'h1FFFF at outLane 5 and 17'h00001 at all other lanes.

Source files
------------

// File: rtl/mac_result_reader_if.sv
// mac_result_reader_if
// Groups the command, MAC-array and result-stream signals of the MAC result
// reader.
//   slave  : the reader itself (takes start/numRows/macOut/outReady and
//            drives COMP/rowResult, the out* result stream, busy and done)
//   master : the environment driving the reader (controller, MAC array and
//            result sink)
// Signals:
//   start     request to read numRows rows
//   numRows   rows to read (0 ignored, >16 clamped to 16)
//   COMP      compute/select strobe to the MAC array
//   rowResult row index presented to the MAC array
//   macOut    16 lanes x 17 bits, lane n on bits [17n+16:17n]
//   outData   result word, outLane/outRow its lane/row index
//   outValid  result word valid; outReady sink accepts it
//   busy      readout in progress; done one-cycle completion pulse
interface mac_result_reader_if;
    logic         start;
    logic [4:0]   numRows;
    logic         COMP;
    logic [3:0]   rowResult;
    logic [271:0] macOut;
    logic [16:0]  outData;
    logic [3:0]   outLane;
    logic [3:0]   outRow;
    logic         outValid;
    logic         outReady;
    logic         busy;
    logic         done;

    modport slave (
        input  start, numRows, macOut, outReady,
        output COMP, rowResult, outData, outLane, outRow, outValid, busy, done
    );

    modport master (
        output start, numRows, macOut, outReady,
        input  COMP, rowResult, outData, outLane, outRow, outValid, busy, done
    );
endinterface

// File: rtl/mac_result_reader.sv
// mac_result_reader
// Reads results out of a 16-lane MAC array row by row. For each row it
// strobes COMP with the row index, waits CAP_DELAY cycles for the array to
// settle, captures all 16 lanes and streams them lane by lane over a
// valid/ready handshake.
// Ports:
//   Clk    clock, all state changes on the rising edge
//   reset  synchronous active-high reset
//   bus    mac_result_reader_if.slave (command, MAC array, result stream)
// Parameter:
//   CAP_DELAY  cycles from the COMP cycle to the macOut capture (1..4)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start with a non-zero row count
// ISSUE | one cycle, COMP=1, rowResult = current row
// WAIT  | CAP_DELAY cycles for the MAC array; macOut captured at the end
// DRAIN | stream buffer[lane] until lane 15 is accepted
module mac_result_reader #(
    parameter int CAP_DELAY = 2
) (
    input  logic              Clk,
    input  logic              reset,
    mac_result_reader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // WAIT is a down-counter loaded with CAP_DELAY-1; terminal count 0 ends it
    localparam logic [1:0] WAIT_LOAD = 2'(CAP_DELAY - 1);

    state_t      state_q, state_d;
    logic [4:0]  nrows_q, nrows_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  lane_q, lane_d;
    logic [1:0]  wait_q, wait_d;
    logic [16:0] out_data_q, out_data_d;
    logic        done_q, done_d;
    logic        capture;
    logic [16:0] buf_q [16];

    always_comb begin
        state_d    = state_q;
        nrows_d    = nrows_q;
        row_d      = row_q;
        lane_d     = lane_q;
        wait_d     = wait_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        capture    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && (bus.numRows != 5'd0)) begin
                    nrows_d = (bus.numRows > 5'd16) ? 5'd16 : bus.numRows;
                    row_d   = 4'd0;
                    lane_d  = 4'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = WAIT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == 2'd0) begin
                    capture    = 1'b1;
                    lane_d     = 4'd0;
                    // lane 0 goes straight from macOut so it is valid
                    // in the first DRAIN cycle
                    out_data_d = bus.macOut[16:0];
                    state_d    = DRAIN;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            DRAIN: begin
                if (bus.outReady) begin
                    if (lane_q == 4'd15) begin
                        lane_d = 4'd0;
                        if (({1'b0, row_q} + 5'd1) < nrows_q) begin
                            row_d   = row_q + 4'd1;
                            state_d = ISSUE;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        lane_d     = lane_q + 4'd1;
                        out_data_d = buf_q[lane_q + 4'd1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= IDLE;
            nrows_q    <= 5'd0;
            row_q      <= 4'd0;
            lane_q     <= 4'd0;
            wait_q     <= 2'd0;
            out_data_q <= 17'd0;
            done_q     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 17'd0;
            end
        end else begin
            state_q    <= state_d;
            nrows_q    <= nrows_d;
            row_q      <= row_d;
            lane_q     <= lane_d;
            wait_q     <= wait_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
            if (capture) begin
                for (int i = 0; i < 16; i++) begin
                    buf_q[i] <= bus.macOut[17*i +: 17];
                end
            end
        end
    end

    // every output is a register or a decode of the state register
    assign bus.COMP      = (state_q == ISSUE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.outValid  = (state_q == DRAIN);
    assign bus.rowResult = row_q;
    assign bus.outRow    = row_q;
    assign bus.outLane   = lane_q;
    assign bus.outData   = out_data_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mac_result_reader.sv
// tb_mac_result_reader
// Randomised bench for mac_result_reader. A MAC array model answers each COMP
// with a per-row pattern, valid only in the capture cycle. A behavioural model
// tracks the expected handshake stream and is compared against the DUT every
// cycle; per-test event counts and a few literal cycle/data expectations pin
// the model itself.
module tb_mac_result_reader;

    localparam int CAP_DELAY = 2;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    always #5 Clk = ~Clk;

    mac_result_reader_if bus ();

    mac_result_reader #(.CAP_DELAY(CAP_DELAY)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- stimulus-side state ----------------
    logic [16:0]  pat [16][16];
    logic         rdy_rand  = 1'b0;
    logic         ones_mode = 1'b0;
    int           test_id   = -1;
    logic         eval_now  = 1'b0;
    int           exp_x = 0, exp_c = 0, exp_d = 0;

    // ---------------- MAC array model ----------------
    logic [271:0] garb = '0;
    int           mac_cnt = 0;
    logic [3:0]   mac_row = 4'd0;

    always @(negedge Clk) begin
        if (bus.COMP === 1'b1) begin
            mac_cnt <= 1;
            mac_row <= bus.rowResult;
        end else if (mac_cnt != 0 && mac_cnt <= CAP_DELAY) begin
            mac_cnt <= mac_cnt + 1;
        end else begin
            mac_cnt <= 0;
        end
        if (ones_mode) begin
            garb <= '1;
        end else begin
            for (int i = 0; i < 16; i++) garb[17*i +: 17] <= 17'($urandom);
        end
    end

    // the row pattern is present only around the edge that ends the last WAIT cycle
    always_comb begin
        bus.macOut = garb;
        if (mac_cnt == CAP_DELAY + 1) begin
            for (int i = 0; i < 16; i++) bus.macOut[17*i +: 17] = pat[mac_row][i];
        end
    end

    always @(posedge Clk) begin
        #1;
        bus.outReady = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- checker + behavioural model ----------------
    int   checks = 0, failures = 0;
    int   ncyc = 0, acc_cyc = 0;
    logic m_known = 1'b0, m_busy = 1'b0, m_drain = 1'b0;
    logic m_comp = 1'b0, m_done = 1'b0, m_rst_chk = 1'b0;
    int   m_row = 0, m_lane = 0, m_n = 0, wcnt = 0;
    int   n_x = 0, n_c = 0, n_d = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d, test %0d)",
                     nm, act, req, ncyc, test_id);
        end
    endtask

    always @(negedge Clk) begin
        int   rel;
        logic nc, nd;
        ncyc++;
        rel = ncyc - acc_cyc;
        if (m_known) begin
            chk("busy",     64'(bus.busy),     64'(m_busy));
            chk("done",     64'(bus.done),     64'(m_done));
            chk("COMP",     64'(bus.COMP),     64'(m_comp));
            chk("outValid", 64'(bus.outValid), 64'(m_drain));
            if (m_rst_chk || test_id == 0) begin
                chk("zero_rowResult", 64'(bus.rowResult), 64'd0);
                chk("zero_outData",   64'(bus.outData),   64'd0);
                chk("zero_outLane",   64'(bus.outLane),   64'd0);
                chk("zero_outRow",    64'(bus.outRow),    64'd0);
            end
            if (m_busy) chk("rowResult", 64'(bus.rowResult), 64'(m_row));
            if (m_drain) begin
                chk("outRow",  64'(bus.outRow),  64'(m_row));
                chk("outLane", 64'(bus.outLane), 64'(m_lane));
                chk("outData", 64'(bus.outData), 64'(pat[m_row][m_lane]));
                if (test_id == 5)
                    chk("lane5_pattern", 64'(bus.outData),
                        (m_lane == 5) ? 64'h1FFFF : 64'h00001);
            end
            if (test_id == 1) begin
                if (bus.COMP) begin
                    chk("t1_comp_cycle", 64'(rel), 64'd1);
                    chk("t1_comp_row",   64'(bus.rowResult), 64'd0);
                end
                if (bus.outValid) begin
                    chk("t1_lane_at_cycle", 64'(bus.outLane), 64'(rel - 4));
                    chk("t1_data_at_cycle", 64'(bus.outData), 64'(rel - 4));
                end
                if (bus.done) chk("t1_done_cycle", 64'(rel), 64'd20);
            end
            if (!reset) begin
                if (bus.COMP) n_c++;
                if (bus.done) n_d++;
                if (bus.outValid && bus.outReady) n_x++;
            end
            if (eval_now) begin
                chk("xfer_count", 64'(n_x), 64'(exp_x));
                chk("comp_count", 64'(n_c), 64'(exp_c));
                chk("done_count", 64'(n_d), 64'(exp_d));
                n_x = 0; n_c = 0; n_d = 0;
            end
        end

        // advance the model to the next cycle
        m_rst_chk = 1'b0;
        if (reset) begin
            m_known = 1'b1; m_busy = 1'b0; m_drain = 1'b0;
            m_comp = 1'b0;  m_done = 1'b0; m_rst_chk = 1'b1;
            m_row = 0; m_lane = 0; wcnt = 0;
        end else begin
            nc = 1'b0;
            nd = 1'b0;
            if (!m_busy) begin
                if (bus.start && bus.numRows != 5'd0) begin
                    m_n = (bus.numRows > 5'd16) ? 16 : int'(bus.numRows);
                    m_row = 0; m_lane = 0; m_busy = 1'b1; nc = 1'b1;
                    acc_cyc = ncyc;
                end
            end else if (m_comp) begin
                wcnt = CAP_DELAY;
            end else if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) begin m_drain = 1'b1; m_lane = 0; end
            end else if (m_drain && bus.outReady) begin
                if (m_lane == 15) begin
                    m_drain = 1'b0; m_lane = 0;
                    if (m_row < m_n - 1) begin m_row++; nc = 1'b1; end
                    else begin m_busy = 1'b0; nd = 1'b1; end
                end else begin
                    m_lane++;
                end
            end
            m_comp = nc;
            m_done = nd;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc_n(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic pulse_start(input int nr);
        bus.start   = 1'b1;
        bus.numRows = 5'(nr);
        cyc_n(1);
        bus.start   = 1'b0;
        bus.numRows = 5'($urandom);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.done) break;
            cyc_n(1);
        end
    endtask

    task automatic end_test(input int x, input int c, input int d);
        cyc_n(3);
        exp_x = x; exp_c = c; exp_d = d;
        eval_now = 1'b1;
        cyc_n(1);
        eval_now = 1'b0;
    endtask

    // mode 0: 17'h100*r+n, mode 1: lane 5 all ones else 1, mode 2: random
    task automatic fill_pat(input int mode);
        for (int r = 0; r < 16; r++)
            for (int n = 0; n < 16; n++)
                case (mode)
                    0:       pat[r][n] = 17'(32'h100 * r + n);
                    1:       pat[r][n] = (n == 5) ? 17'h1FFFF : 17'h00001;
                    default: pat[r][n] = 17'($urandom);
                endcase
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.numRows = 5'd0;
        fill_pat(2);

        // idle with macOut all ones
        ones_mode = 1'b1;
        cyc_n(3);
        reset = 1'b0;
        test_id = 0;
        cyc_n(50);
        end_test(0, 0, 0);
        ones_mode = 1'b0;

        // single row, literal timing
        test_id = 1;
        fill_pat(0);
        rdy_rand = 1'b0;
        pulse_start(1);
        wait_done(100);
        end_test(16, 1, 1);

        // 16 rows with random back-pressure
        test_id = 2;
        fill_pat(2);
        rdy_rand = 1'b1;
        pulse_start(16);
        wait_done(3000);
        end_test(256, 16, 1);

        // ignored starts, clamping, start in done cycle
        test_id = 3;
        fill_pat(2);
        pulse_start(0);
        cyc_n(5);
        pulse_start(20);
        cyc_n(30);
        pulse_start(5);
        wait_done(3000);
        pulse_start(2);
        wait_done(1000);
        end_test(256 + 32, 16 + 2, 2);

        // reset during DRAIN row 3 lane 7, then immediate restart
        test_id = 4;
        fill_pat(2);
        rdy_rand = 1'b0;
        pulse_start(5);
        for (int i = 0; i < 500; i++) begin
            if (bus.outValid && bus.outRow == 4'd3 && bus.outLane == 4'd7) break;
            cyc_n(1);
        end
        reset = 1'b1;
        cyc_n(1);
        reset = 1'b0;
        pulse_start(2);
        wait_done(500);
        end_test(48 + 7 + 32, 4 + 2, 1);

        // lane 5 full-width pattern
        test_id = 5;
        fill_pat(1);
        rdy_rand = 1'b1;
        pulse_start(3);
        wait_done(1000);
        end_test(48, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
